// File: rtl/mem_bus_if.sv
// Handshake bundle between the core-side master and the memory/bus responder.
interface mem_bus_if;
    logic        req;
    logic        RD_WR;
    logic [19:0] Direction;
    logic [15:0] Data_in;
    logic [15:0] Data_out;
    logic        data_oe;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output req, RD_WR, Direction, Data_in,
        input  Data_out, data_oe, ready, busy, err
    );

    modport slave (
        input  req, RD_WR, Direction, Data_in,
        output Data_out, data_oe, ready, busy, err
    );
endinterface

// File: rtl/mem_bus_responder.sv
// Word-addressed memory slave with programmable wait states, a one-cycle ready
// pulse and an out-of-range flag for addresses above the decoded window.
module mem_bus_responder #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] OOR_DATA    = 16'hFFFF
) (
    input  logic     clk,
    input  logic     reset,
    mem_bus_if.slave bus
);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        accept;

    logic        lat_rd_wr;
    logic [19:0] lat_addr;
    logic [15:0] lat_data;

    logic        busy_q, ready_q, oe_q, err_q;
    logic [15:0] dout_q;

    logic [15:0] mem [2**ADDR_W];

    logic [ADDR_W-1:0] idx;
    logic              oor;

    assign idx = lat_addr[ADDR_W-1:0];
    assign oor = (lat_addr >> ADDR_W) != 20'd0;

    // Requests are only taken when not busy; busy also covers the ready cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req && !busy_q) begin
                    accept = 1'b1;
                    if (WS != 4'd0) begin
                        state_next = WAIT;
                        cnt_next   = WS;
                    end else begin
                        state_next = ACCESS;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
            oe_q      <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= 16'h0000;
            lat_rd_wr <= 1'b0;
            lat_addr  <= 20'd0;
            lat_data  <= 16'h0000;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            ready_q <= 1'b0;
            oe_q    <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 16'h0000;
            if (accept) begin
                lat_rd_wr <= bus.RD_WR;
                lat_addr  <= bus.Direction;
                lat_data  <= bus.Data_in;
                busy_q    <= 1'b1;
            end else if (ready_q) begin
                busy_q <= 1'b0;
            end
            if (state == ACCESS) begin
                ready_q <= 1'b1;
                err_q   <= oor;
                if (!lat_rd_wr) begin
                    oe_q   <= 1'b1;
                    dout_q <= oor ? OOR_DATA : mem[idx];
                end
            end
        end
    end

    // Storage is deliberately left out of reset; an aborted write never lands.
    always_ff @(posedge clk) begin
        if (!reset && state == ACCESS && lat_rd_wr && !oor) begin
            mem[idx] <= lat_data;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.ready    = ready_q;
    assign bus.data_oe  = oe_q;
    assign bus.err      = err_q;
    assign bus.Data_out = dout_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a 2-wait-state and a 0-wait-state build
// checked against a scoreboard fed by a small reference memory model.
module tb_mem_bus_responder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req2, req0, rdWr;
    logic [19:0] dir;
    logic [15:0] din;

    mem_bus_if bus2();
    mem_bus_if bus0();

    assign bus2.req       = req2;
    assign bus2.RD_WR     = rdWr;
    assign bus2.Direction = dir;
    assign bus2.Data_in   = din;
    assign bus0.req       = req0;
    assign bus0.RD_WR     = rdWr;
    assign bus0.Direction = dir;
    assign bus0.Data_in   = din;

    mem_bus_responder #(.ADDR_W(10), .WAIT_STATES(2), .OOR_DATA(16'hFFFF)) dut2 (
        .clk(clk), .reset(reset), .bus(bus2.slave));
    mem_bus_responder #(.ADDR_W(10), .WAIT_STATES(0), .OOR_DATA(16'hFFFF)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave));

    typedef struct {
        logic [15:0] data;
        logic        oe;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] model2 [int];
    logic [15:0] model0 [int];
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sReady(input bit fast);
        return fast ? bus0.ready : bus2.ready;
    endfunction
    function automatic logic sBusy(input bit fast);
        return fast ? bus0.busy : bus2.busy;
    endfunction
    function automatic logic sOe(input bit fast);
        return fast ? bus0.data_oe : bus2.data_oe;
    endfunction
    function automatic logic sErr(input bit fast);
        return fast ? bus0.err : bus2.err;
    endfunction
    function automatic logic [15:0] sDout(input bit fast);
        return fast ? bus0.Data_out : bus2.Data_out;
    endfunction

    task automatic checkIdle(input bit fast, input string tag);
        check({tag, "_ready"}, 32'(sReady(fast)), 32'd0);
        check({tag, "_busy"},  32'(sBusy(fast)),  32'd0);
        check({tag, "_oe"},    32'(sOe(fast)),    32'd0);
        check({tag, "_err"},   32'(sErr(fast)),   32'd0);
        check({tag, "_dout"},  32'(sDout(fast)),  32'd0);
    endtask

    task automatic checkOutput(input bit fast, input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({tag, "_dout"}, 32'(sDout(fast)), 32'(e.data));
        check({tag, "_oe"},   32'(sOe(fast)),   32'(e.oe));
        check({tag, "_err"},  32'(sErr(fast)),  32'(e.err));
        check({tag, "_busy_rdy"}, 32'(sBusy(fast)), 32'd1);
    endtask

    // One request: drive, push expectation at accept, wait for ready, compare.
    task automatic applyStimulus(input bit fast, input bit wr, input logic [19:0] addr,
                                 input logic [15:0] data, input bit pulse, input string tag);
        int   ws;
        int   lat;
        int   rdyCount;
        int   idx;
        bit   oor;
        exp_t e;
        ws  = fast ? 0 : 2;
        idx = int'(addr[9:0]);
        oor = (addr[19:10] != 10'd0);
        rdWr = wr;
        dir  = addr;
        din  = data;
        if (fast) req0 = 1'b1; else req2 = 1'b1;
        tick();
        e.oe  = !wr;
        e.err = oor;
        if (wr) e.data = 16'h0000;
        else if (oor) e.data = 16'hFFFF;
        else e.data = fast ? model0[idx] : model2[idx];
        if (wr && !oor) begin
            if (fast) model0[idx] = data; else model2[idx] = data;
        end
        sb.push_back(e);
        if (!pulse) begin
            if (fast) req0 = 1'b0; else req2 = 1'b0;
            rdWr = ~wr;
            dir  = ~addr;
            din  = ~data;
        end
        check({tag, "_busy_acc"}, 32'(sBusy(fast)), 32'd1);
        lat = 0;
        rdyCount = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (sReady(fast)) break;
            check({tag, "_busy_wait"}, 32'(sBusy(fast)), 32'd1);
        end
        check({tag, "_latency"}, 32'(lat), 32'(ws + 1));
        if (sReady(fast)) rdyCount++;
        checkOutput(fast, tag);
        tick();
        if (fast) req0 = 1'b0; else req2 = 1'b0;
        if (sReady(fast)) rdyCount++;
        checkIdle(fast, {tag, "_after"});
        if (pulse) begin
            repeat (3) begin
                tick();
                if (sReady(fast)) rdyCount++;
                check({tag, "_no_accept"}, 32'(sBusy(fast)), 32'd0);
            end
            check({tag, "_ready_count"}, 32'(rdyCount), 32'd1);
        end
    endtask

    initial begin
        reset = 1'b1;
        req2  = 1'b0;
        req0  = 1'b0;
        rdWr  = 1'b0;
        dir   = 20'd0;
        din   = 16'h0000;

        $display("[TB] reset");
        tick();
        tick();
        checkIdle(1'b0, "t1_ws2");
        checkIdle(1'b1, "t1_ws0");
        reset = 1'b0;
        tick();

        $display("[TB] write/read with two wait states");
        applyStimulus(1'b0, 1'b1, 20'h00010, 16'hA55A, 1'b0, "t2_wr");
        applyStimulus(1'b0, 1'b0, 20'h00010, 16'h0000, 1'b0, "t2_rd");

        $display("[TB] out-of-range access");
        applyStimulus(1'b0, 1'b1, 20'h00000, 16'h1111, 1'b0, "t3_wr0");
        applyStimulus(1'b0, 1'b0, 20'h80000, 16'h0000, 1'b0, "t3_rd_oor");
        applyStimulus(1'b0, 1'b1, 20'h80000, 16'h9999, 1'b0, "t3_wr_oor");
        applyStimulus(1'b0, 1'b0, 20'h00000, 16'h0000, 1'b0, "t3_rd0");

        $display("[TB] req held high during a read");
        applyStimulus(1'b0, 1'b0, 20'h00010, 16'h0000, 1'b1, "t4_pulse");

        $display("[TB] reset during wait states");
        applyStimulus(1'b0, 1'b1, 20'h00005, 16'h5678, 1'b0, "t5_pre");
        rdWr = 1'b1;
        dir  = 20'h00005;
        din  = 16'h1234;
        req2 = 1'b1;
        tick();
        req2 = 1'b0;
        check("t5_busy_acc", 32'(bus2.busy), 32'd1);
        tick();
        check("t5_wait_ready", 32'(bus2.ready), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkIdle(1'b0, "t5_rst");
        repeat (4) begin
            tick();
            check("t5_no_ready", 32'(bus2.ready), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 20'h00005, 16'h0000, 1'b0, "t5_rd");

        $display("[TB] zero wait-state build");
        applyStimulus(1'b1, 1'b1, 20'h003FF, 16'hBEEF, 1'b0, "t6_wr");
        applyStimulus(1'b1, 1'b0, 20'h003FF, 16'h0000, 1'b0, "t6_rd");
        applyStimulus(1'b1, 1'b0, 20'h00400, 16'h0000, 1'b0, "t6_rd_oor");

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
